// File: rtl/spi_master_comm.sv
// SPI master frame controller: CMD, ADDR[15:8], ADDR[7:0], DATA per frame, mode 0.
// Define SPI_MASTER_ERR_EN to abort a frame when the slave STA byte has bit 7 set.
`timescale 1ns/1ps
module spi_master_comm #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr,
  input  logic [7:0]  CMD_in,
  input  logic [15:0] ADDR_in,
  input  logic [7:0]  DATA_in,
  output logic [7:0]  STA_out,
  output logic [7:0]  DATA_out,
  output logic        busy,
  output logic        done,
  output logic        EoB,
  output logic        err,
  output logic        SCLK,
  output logic        SS,
  output logic        MOSI,
  input  logic        MISO
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_master_comm: CLK_DIV must be >= 2");
  end

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          phase;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          wr_q;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic          miso_s1;
  logic          miso_s2;
  logic          half_end;
  logic          abort;
  logic [7:0]    nxt_byte;

  assign half_end = (div_cnt == DIV_LAST);

`ifdef SPI_MASTER_ERR_EN
  assign abort = (byte_cnt == 2'd0) && rx_sr[7];
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    nxt_byte = 8'h00;
    case (byte_cnt)
      2'd0:    nxt_byte = addr_q[15:8];
      2'd1:    nxt_byte = addr_q[7:0];
      2'd2:    nxt_byte = wr_q ? data_q : 8'h00;
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= MISO;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      SS       <= 1'b1;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      EoB      <= 1'b0;
      STA_out  <= 8'h00;
      DATA_out <= 8'h00;
      div_cnt  <= '0;
      phase    <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
`ifdef SPI_MASTER_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      EoB  <= 1'b0;
      unique case (state)
        IDLE: begin
          SCLK <= 1'b0;
          if (start) begin
            wr_q    <= wr;
            addr_q  <= ADDR_in;
            data_q  <= DATA_in;
            tx_sr   <= CMD_in;
            MOSI    <= CMD_in[7];
            SS      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            state   <= SETUP;
`ifdef SPI_MASTER_ERR_EN
            err     <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (half_end) begin
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            state    <= XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        XFER: begin
          if (!half_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!phase) begin
              SCLK  <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso_s2};
              phase <= 1'b1;
            end else begin
              SCLK    <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // byte boundary: publish rx byte, load next tx byte
                EoB <= 1'b1;
                if (byte_cnt == 2'd0) begin
                  STA_out <= rx_sr;
`ifdef SPI_MASTER_ERR_EN
                  err     <= rx_sr[7];
`endif
                end
                if (byte_cnt == 2'd3) begin
                  DATA_out <= rx_sr;
                end
                if (byte_cnt == 2'd3 || abort) begin
                  MOSI  <= 1'b0;
                  state <= HOLD;
                end else begin
                  tx_sr    <= nxt_byte;
                  MOSI     <= nxt_byte[7];
                  byte_cnt <= byte_cnt + 2'd1;
                end
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                MOSI  <= tx_sr[6];
              end
            end
          end
        end
        HOLD: begin
          if (half_end) begin
            div_cnt <= '0;
            SS      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
